objf_iter_ctrl: RTL

Iteration sequencer for the objective/gradient evaluator in the 3D-face fitting datapath. Owns the 50-entry identity-coefficient vector, drives the evaluator through one cost pass and one finite-difference gradient pass per iteration, then applies a per-element update through a shared external FP update unit (id ← id − lr·grad). It runs MAX_ITER iterations or until aborted, and reports the per-iteration cost.

---
 rtl/objf_iter_ctrl_if.sv | 55 +++++
 rtl/objf_iter_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/objf_iter_ctrl_if.sv
// Bundle between the iteration sequencer, its host, the objective/gradient evaluator and the FP update unit.
// master = sequencer side, slave = host/evaluator/update-unit side.
interface objf_iter_ctrl_if #(
  parameter int NUM_ELEMENTS = 50,
  parameter int DATA_WIDTH   = 64,
  parameter int ITER_W       = 16
);
  // run control and status
  logic                                     start;
  logic                                     abort;
  logic [ITER_W-1:0]                        max_iter;
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  id_init;
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  id_vec;
  logic [DATA_WIDTH-1:0]                    cost;
  logic                                     cost_valid;
  logic [ITER_W-1:0]                        iter;
  logic                                     busy;
  logic                                     done;
  logic                                     err;

  // evaluator
  logic                                     eval_rst;
  logic                                     eval_op;
  logic                                     eval_valid_f;
  logic [DATA_WIDTH-1:0]                    eval_result_f;
  logic                                     eval_valid_g;
  logic [DATA_WIDTH-1:0]                    eval_result_g;
  logic                                     eval_over_g;

  // shared update unit
  logic                                     upd_req;
  logic [DATA_WIDTH-1:0]                    upd_a;
  logic [DATA_WIDTH-1:0]                    upd_b;
  logic [5:0]                               upd_idx;
  logic                                     upd_ack;
  logic [DATA_WIDTH-1:0]                    upd_result;

  modport master (
    input  start, abort, max_iter, id_init,
    input  eval_valid_f, eval_result_f, eval_valid_g, eval_result_g, eval_over_g,
    input  upd_ack, upd_result,
    output id_vec, cost, cost_valid, iter, busy, done, err,
    output eval_rst, eval_op,
    output upd_req, upd_a, upd_b, upd_idx
  );

  modport slave (
    output start, abort, max_iter, id_init,
    output eval_valid_f, eval_result_f, eval_valid_g, eval_result_g, eval_over_g,
    output upd_ack, upd_result,
    input  id_vec, cost, cost_valid, iter, busy, done, err,
    input  eval_rst, eval_op,
    input  upd_req, upd_a, upd_b, upd_idx
  );
endinterface

// File: rtl/objf_iter_ctrl.sv
// Fitting-loop sequencer: cost pass, gradient pass, per-element update (id -= lr*grad) for max_iter iterations.
// All outputs registered; update unit handshakes by upd_req held until upd_ack, then >=1 idle cycle per element.
module objf_iter_ctrl #(
  parameter int NUM_ELEMENTS = 50,
  parameter int DATA_WIDTH   = 64,
  parameter int ITER_W       = 16,
  parameter int EVAL_RST_CYC = 2,
  parameter int WDOG_CYC     = 65535
) (
  input  logic             clk,
  input  logic             rst,
  objf_iter_ctrl_if.master bus
);

  localparam int IDX_W  = 6;
  localparam int GCNT_W = $clog2(NUM_ELEMENTS + 2);
  localparam int RC_W   = (EVAL_RST_CYC > 1) ? $clog2(EVAL_RST_CYC) : 1;
  localparam int WD_W   = $clog2(WDOG_CYC + 1);

  localparam logic [GCNT_W-1:0] GCNT_FULL = GCNT_W'(NUM_ELEMENTS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ELEMENTS - 1);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(EVAL_RST_CYC - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WDOG_CYC - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRST,
    S_FWAIT,
    S_GRST,
    S_GCOL,
    S_UREQ,
    S_UWAIT,
    S_FIN
  } state_t;

  state_t                              state;
  state_t                              state_nxt;

  logic [RC_W-1:0]                     rst_cnt;
  logic [WD_W-1:0]                     wdog;
  logic [GCNT_W-1:0]                   gcnt;
  logic [GCNT_W-1:0]                   gcnt_inc;
  logic [IDX_W-1:0]                    idx;
  logic [ITER_W-1:0]                   iter_q;
  logic [ITER_W-1:0]                   max_q;
  logic                                final_pass;

  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] id_q;
  word_t                               grad_buf [NUM_ELEMENTS];

  word_t                               cost_q;
  logic                                cost_valid_q;
  logic                                eval_rst_q;
  logic                                eval_op_q;
  logic                                upd_req_q;
  word_t                               upd_a_q;
  word_t                               upd_b_q;
  logic [IDX_W-1:0]                    upd_idx_q;
  logic                                busy_q;
  logic                                done_q;
  logic                                err_q;

  // per-cycle events decided by the FSM, all suppressed by abort
  logic                                do_start;
  logic                                cap_cost;
  logic                                wr_grad;
  logic                                wr_upd;
  logic                                set_err;
  logic                                upd_hs;
  logic                                wd_hit;
  logic                                in_wait;

  assign upd_hs  = upd_req_q && bus.upd_ack;
  assign wd_hit  = (wdog >= WD_LAST);
  assign in_wait = (state == S_FWAIT) || (state == S_GCOL) || (state == S_UWAIT);

  // Saturates one past full so surplus gradient pulses still register as a count error.
  assign gcnt_inc = (bus.eval_valid_g && (gcnt <= GCNT_FULL)) ? gcnt + GCNT_W'(1) : gcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    cap_cost  = 1'b0;
    wr_grad   = 1'b0;
    wr_upd    = 1'b0;
    set_err   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          do_start  = 1'b1;
          state_nxt = S_FRST;
        end
      end
      S_FRST: begin
        if (rst_cnt == RC_LAST) state_nxt = S_FWAIT;
      end
      S_FWAIT: begin
        if (bus.eval_valid_f) begin
          cap_cost  = 1'b1;
          state_nxt = final_pass ? S_FIN : S_GRST;
        end else if (wd_hit) begin
          set_err   = 1'b1;
          state_nxt = S_FIN;
        end
      end
      S_GRST: begin
        if (rst_cnt == RC_LAST) state_nxt = S_GCOL;
      end
      S_GCOL: begin
        wr_grad = bus.eval_valid_g;
        if (bus.eval_over_g) begin
          if (gcnt_inc != GCNT_FULL) begin
            set_err   = 1'b1;
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_UREQ;
          end
        end else if (wd_hit && !bus.eval_valid_g) begin
          set_err   = 1'b1;
          state_nxt = S_FIN;
        end
      end
      S_UREQ: begin
        state_nxt = S_UWAIT;
      end
      S_UWAIT: begin
        if (upd_hs) begin
          wr_upd    = 1'b1;
          state_nxt = (idx == IDX_LAST) ? S_FRST : S_UREQ;
        end else if (wd_hit) begin
          set_err   = 1'b1;
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_nxt = S_IDLE;
      do_start  = 1'b0;
      cap_cost  = 1'b0;
      wr_grad   = 1'b0;
      wr_upd    = 1'b0;
      set_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_cnt      <= '0;
      wdog         <= '0;
      gcnt         <= '0;
      idx          <= '0;
      iter_q       <= '0;
      max_q        <= ITER_W'(1);
      final_pass   <= 1'b0;
      id_q         <= '0;
      cost_q       <= '0;
      cost_valid_q <= 1'b0;
      eval_rst_q   <= 1'b0;
      eval_op_q    <= 1'b0;
      upd_req_q    <= 1'b0;
      upd_a_q      <= '0;
      upd_b_q      <= '0;
      upd_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cost_valid_q <= cap_cost;
      eval_rst_q   <= (state_nxt == S_FWAIT) || (state_nxt == S_GCOL);
      upd_req_q    <= (state_nxt == S_UWAIT);
      busy_q       <= (state_nxt != S_IDLE) && (state_nxt != S_FIN);

      // The pass type only moves together with eval_rst falling, so it is stable for a whole pass.
      if (state_nxt == S_FRST) begin
        eval_op_q <= 1'b0;
      end else if (state_nxt == S_GRST) begin
        eval_op_q <= 1'b1;
      end

      if ((state_nxt != state) || !((state == S_FRST) || (state == S_GRST))) begin
        rst_cnt <= '0;
      end else begin
        rst_cnt <= rst_cnt + RC_W'(1);
      end

      if ((state_nxt != state) || wr_grad || !in_wait) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + WD_W'(1);
      end

      if (do_start) begin
        id_q       <= bus.id_init;
        iter_q     <= '0;
        idx        <= '0;
        final_pass <= 1'b0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        max_q      <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
      end

      if (cap_cost) begin
        cost_q <= bus.eval_result_f;
      end

      if (state == S_GRST) begin
        gcnt <= '0;
      end else if (wr_grad) begin
        gcnt <= gcnt_inc;
      end

      if ((state == S_UREQ) && (state_nxt == S_UWAIT)) begin
        upd_a_q   <= id_q[idx];
        upd_b_q   <= grad_buf[idx];
        upd_idx_q <= idx;
      end

      if (wr_upd) begin
        id_q[idx] <= bus.upd_result;
        if (idx == IDX_LAST) begin
          idx    <= '0;
          iter_q <= iter_q + ITER_W'(1);
          if ((iter_q + ITER_W'(1)) == max_q) final_pass <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end

      if (set_err) begin
        err_q <= 1'b1;
      end

      if ((state_nxt == S_FIN) && (state != S_FIN)) begin
        done_q <= !set_err;
      end
    end
  end

  // Gradient storage needs no reset: every entry is rewritten before the update phase reads it.
  always_ff @(posedge clk) begin
    if (wr_grad && (gcnt < GCNT_FULL)) begin
      grad_buf[gcnt] <= bus.eval_result_g;
    end
  end

  assign bus.id_vec     = id_q;
  assign bus.cost       = cost_q;
  assign bus.cost_valid = cost_valid_q;
  assign bus.iter       = iter_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.eval_rst   = eval_rst_q;
  assign bus.eval_op    = eval_op_q;
  assign bus.upd_req    = upd_req_q;
  assign bus.upd_a      = upd_a_q;
  assign bus.upd_b      = upd_b_q;
  assign bus.upd_idx    = upd_idx_q;

endmodule
